// File: rtl/sram_burst_pkg.sv
// Shared types and helpers for the SRAM burst reader and its output FIFO.
package sram_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Width needed to hold an occupancy count from 0 to depth inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_rd_fifo.sv
// Synchronous output FIFO for the burst reader; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sram_rd_fifo
  import sram_burst_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [fifo_cnt_w(DEPTH)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = fifo_cnt_w(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/sram_burst_reader.sv
// Reads a burst of consecutive SRAM words and streams them out with credit-based
// issue. Define SRAM_BURST_READER_ERRCHK_EN to enable the sticky protocol checker.
module sram_burst_reader
  import sram_burst_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic              a_en,
  output logic              a_re,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_rdata,
  input  logic              a_rvalid,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = fifo_cnt_w(FIFO_DEPTH);
  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ISSUE = ST_ISSUE;
  localparam logic [1:0] DRAIN = ST_DRAIN;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] len;
  // One extra bit so a full-memory burst (2^ADDR_W words) can be counted.
  logic [ADDR_W:0]   issue_count;
  logic [ADDR_W:0]   resp_count;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic [DATA_W:0]   head;
  logic              fifo_empty;
  logic              issue;
  logic              last_issue;
  logic              resp;
  logic              push_last;
  logic              pop;
  logic              last_pop;
  logic              done_q;
`ifdef SRAM_BURST_READER_ERRCHK_EN
  logic              fifo_full;
  logic              err_q;
`endif

  assign credit_used = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight);
  assign issue       = !rst && (state == ISSUE) && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign last_issue  = issue && (issue_count == {1'b0, len});
  assign resp        = a_rvalid && (inflight != '0);
  assign push_last   = (resp_count == {1'b0, len});
  assign pop         = m_valid && m_ready;
  assign last_pop    = pop && head[DATA_W];

  assign a_en      = issue;
  assign a_re      = issue;
  assign a_addr    = base_addr + issue_count[ADDR_W-1:0];
  assign cmd_ready = !rst && (state == IDLE);
  assign busy      = !rst && (state != IDLE);
  assign done      = !rst && done_q;
  assign m_valid   = !rst && !fifo_empty;
  assign m_data    = head[DATA_W-1:0];
  assign m_last    = head[DATA_W];

  // Burst sequencing; a reset mid-burst simply drops everything without a done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      base_addr   <= '0;
      len         <= '0;
      issue_count <= '0;
      resp_count  <= '0;
      inflight    <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (resp) resp_count <= resp_count + 1'b1;
      case ({issue, resp})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            base_addr   <= cmd_addr;
            len         <= cmd_len;
            issue_count <= '0;
            resp_count  <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue)      issue_count <= issue_count + 1'b1;
          if (last_issue) state       <= DRAIN;
        end
        default: state <= state;
      endcase
      if ((state != IDLE) && last_pop) begin
        state  <= IDLE;
        done_q <= 1'b1;
      end
    end
  end

  sram_rd_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (resp),
    .push_data ({push_last, a_rdata}),
    .pop       (pop),
    .pop_data  (head),
`ifdef SRAM_BURST_READER_ERRCHK_EN
    .full      (fifo_full),
`else
    .full      (),
`endif
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef SRAM_BURST_READER_ERRCHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((a_rvalid && (inflight == '0)) || (resp && fifo_full && !pop)) begin
      err_q <= 1'b1;
    end
  end

  assign err = !rst && err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_burst_reader.sv
// Scoreboard bench for sram_burst_reader against an identity SRAM model
// (mem[i] = i) with a fixed read latency.
module tb_sram_burst_reader;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int RD_LAT     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [ADDR_W-1:0] cmd_len = '0;
  logic              a_en;
  logic              a_re;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_rdata;
  logic              a_rvalid;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              busy;
  logic              done;
  logic              err;
  logic              inject = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_count = 0;

  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W:0]   beat_q[$];
  logic [ADDR_W-1:0] issued_q[$];
  int                issue_cyc_q[$];

  always #5 clk = ~clk;

  sram_burst_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .a_en      (a_en),
    .a_re      (a_re),
    .a_addr    (a_addr),
    .a_rdata   (a_rdata),
    .a_rvalid  (a_rvalid),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // SRAM model: a request in cycle t returns its address as data in cycle t+RD_LAT.
  logic [RD_LAT-1:0] pipe_v;
  logic [ADDR_W-1:0] pipe_addr [RD_LAT];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0]    <= a_en && a_re;
      pipe_addr[0] <= a_addr;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_v[k]    <= pipe_v[k-1];
        pipe_addr[k] <= pipe_addr[k-1];
      end
    end
  end

  assign a_rvalid = pipe_v[RD_LAT-1] | inject;
  assign a_rdata  = inject ? 32'hDEAD_BEEF : DATA_W'(pipe_addr[RD_LAT-1]);

  always @(negedge clk) begin
    if (!rst) begin
      if (a_en) begin
        issued_q.push_back(a_addr);
        issue_cyc_q.push_back(cyc);
      end
      if (m_valid && m_ready) beat_q.push_back({m_last, m_data});
      if (done) done_count++;
    end
  end

  task automatic clear_queues();
    exp_q.delete();
    beat_q.delete();
    issued_q.delete();
    issue_cyc_q.delete();
    done_count = 0;
  endtask

  task automatic send_cmd(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] len);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    for (int i = 0; i <= int'(len); i++)
      exp_q.push_back({(i == int'(len)), DATA_W'((int'(addr) + i) % (1 << ADDR_W))});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // mode 0: m_ready high, 1: random 50%, 2: low
  task automatic run_until_done(input int mode, input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, a_en, a_re, m_valid, busy, done, err} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%b want=0000000",
               {cmd_ready, a_en, a_re, m_valid, busy, done, err});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, m_valid} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL reset_release got=%b want=100", {cmd_ready, busy, m_valid});
    end
  endtask

  task automatic test_basic();
    bit to;
    logic [ADDR_W-1:0] want_addr [4] = '{10'd5, 10'd6, 10'd7, 10'd8};
    logic [DATA_W:0] e, o;
    clear_queues();
    m_ready = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_cmd_ready got=%b want=1", cmd_ready);
    end
    send_cmd(10'd5, 10'd3);
    run_until_done(0, 100, to);
    repeat (3) @(negedge clk);
    checks++;
    if (to !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_timeout got=%b want=0", to);
    end
    checks++;
    if (issued_q.size() !== 4) begin
      failures++;
      $display("[TB] FAIL basic_issue_count got=%0d want=4", issued_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (issued_q[i] !== want_addr[i]) begin
          failures++;
          $display("[TB] FAIL basic_addr[%0d] got=%0d want=%0d", i, issued_q[i], want_addr[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (issue_cyc_q[i] - issue_cyc_q[i-1] !== 1) begin
          failures++;
          $display("[TB] FAIL basic_addr_gap[%0d] got=%0d want=1", i, issue_cyc_q[i] - issue_cyc_q[i-1]);
        end
      end
    end
    checks++;
    if (beat_q.size() !== exp_q.size()) begin
      failures++;
      $display("[TB] FAIL basic_beat_count got=%0d want=%0d", beat_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && beat_q.size() > 0) begin
      e = exp_q.pop_front();
      o = beat_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL basic_beat got=%h want=%h", o, e);
      end
    end
    checks++;
    if (done_count !== 1) begin
      failures++;
      $display("[TB] FAIL basic_done_count got=%0d want=1", done_count);
    end
  endtask

  task automatic test_wrap();
    bit to;
    logic [ADDR_W-1:0] want_addr [4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    logic [DATA_W:0] e, o;
    clear_queues();
    send_cmd(10'd1022, 10'd3);
    run_until_done(0, 100, to);
    checks++;
    if (to !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrap_timeout got=%b want=0", to);
    end
    checks++;
    if (issued_q.size() !== 4) begin
      failures++;
      $display("[TB] FAIL wrap_issue_count got=%0d want=4", issued_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (issued_q[i] !== want_addr[i]) begin
          failures++;
          $display("[TB] FAIL wrap_addr[%0d] got=%0d want=%0d", i, issued_q[i], want_addr[i]);
        end
      end
    end
    while (exp_q.size() > 0 && beat_q.size() > 0) begin
      e = exp_q.pop_front();
      o = beat_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL wrap_beat got=%h want=%h", o, e);
      end
    end
    checks++;
    if (exp_q.size() + beat_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL wrap_leftover got=%0d want=0", exp_q.size() + beat_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [DATA_W:0] e, o;
    clear_queues();
    m_ready = 1'b0;
    send_cmd(10'd40, 10'd15);
    repeat (20) @(negedge clk);
    checks++;
    if (issued_q.size() !== FIFO_DEPTH) begin
      failures++;
      $display("[TB] FAIL bp_issued got=%0d want=%0d", issued_q.size(), FIFO_DEPTH);
    end
    checks++;
    if ({m_valid, busy, err} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL bp_status got=%b want=110", {m_valid, busy, err});
    end
    checks++;
    if ({m_last, m_data} !== exp_q[0]) begin
      failures++;
      $display("[TB] FAIL bp_head got=%h want=%h", {m_last, m_data}, exp_q[0]);
    end
    run_until_done(0, 200, to);
    checks++;
    if (to !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_timeout got=%b want=0", to);
    end
    checks++;
    if (beat_q.size() !== 16) begin
      failures++;
      $display("[TB] FAIL bp_beat_count got=%0d want=16", beat_q.size());
    end
    while (exp_q.size() > 0 && beat_q.size() > 0) begin
      e = exp_q.pop_front();
      o = beat_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL bp_beat got=%h want=%h", o, e);
      end
    end
  endtask

  task automatic test_random_ready();
    bit to;
    logic [DATA_W:0] e, o;
    clear_queues();
    send_cmd(10'd300, 10'd63);
    run_until_done(1, 1000, to);
    checks++;
    if (to !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rand_timeout got=%b want=0", to);
    end
    checks++;
    if (beat_q.size() !== 64) begin
      failures++;
      $display("[TB] FAIL rand_beat_count got=%0d want=64", beat_q.size());
    end
    while (exp_q.size() > 0 && beat_q.size() > 0) begin
      e = exp_q.pop_front();
      o = beat_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL rand_beat got=%h want=%h", o, e);
      end
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rand_err got=%b want=0", err);
    end
  endtask

  task automatic test_full_memory();
    bit to;
    logic [DATA_W:0] e, o;
    clear_queues();
    send_cmd(10'd0, 10'd1023);
    run_until_done(0, 1500, to);
    checks++;
    if (to !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_timeout got=%b want=0", to);
    end
    checks++;
    if (issued_q.size() !== 1024) begin
      failures++;
      $display("[TB] FAIL full_issue_count got=%0d want=1024", issued_q.size());
    end
    checks++;
    if (beat_q.size() !== 1024) begin
      failures++;
      $display("[TB] FAIL full_beat_count got=%0d want=1024", beat_q.size());
    end
    while (exp_q.size() > 0 && beat_q.size() > 0) begin
      e = exp_q.pop_front();
      o = beat_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL full_beat got=%h want=%h", o, e);
      end
    end
  endtask

  task automatic test_abort();
    bit to;
    logic [DATA_W:0] e, o;
    clear_queues();
    m_ready = 1'b1;
    send_cmd(10'd100, 10'd7);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, a_en, a_re, m_valid, busy, done, err} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL abort_outputs got=%b want=0000000",
               {cmd_ready, a_en, a_re, m_valid, busy, done, err});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    done_count = 0;
    repeat (12) @(negedge clk);
    checks++;
    if (done_count !== 0) begin
      failures++;
      $display("[TB] FAIL abort_done got=%0d want=0", done_count);
    end
    checks++;
    if ({cmd_ready, busy, m_valid} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL abort_idle got=%b want=100", {cmd_ready, busy, m_valid});
    end
    clear_queues();
    send_cmd(10'd0, 10'd0);
    run_until_done(0, 50, to);
    checks++;
    if (to !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_next_timeout got=%b want=0", to);
    end
    checks++;
    if (beat_q.size() !== 1) begin
      failures++;
      $display("[TB] FAIL abort_next_count got=%0d want=1", beat_q.size());
    end
    while (exp_q.size() > 0 && beat_q.size() > 0) begin
      e = exp_q.pop_front();
      o = beat_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL abort_next_beat got=%h want=%h", o, e);
      end
    end
  endtask

  task automatic test_spurious();
    logic want_err;
`ifdef SRAM_BURST_READER_ERRCHK_EN
    want_err = 1'b1;
`else
    want_err = 1'b0;
`endif
    clear_queues();
    @(posedge clk); #1;
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (err !== want_err) begin
        failures++;
        $display("[TB] FAIL spur_err[%0d] got=%b want=%b", i, err, want_err);
      end
    end
    checks++;
    if ({m_valid, busy} !== 2'b00 || beat_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL spur_ignored got=%b/%0d want=00/0", {m_valid, busy}, beat_q.size());
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL spur_err_cleared got=%b want=0", err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_random_ready();
    test_full_memory();
    test_abort();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
